// File: rtl/aq_axi_sdma64_pkg.sv
// Shared constants for the 64-bit AXI write DMA master: FSM encodings,
// fixed AXI attributes and the burst-length rule.
package aq_axi_sdma64_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  localparam logic [2:0] SIZE_64       = 3'b011;
  localparam logic [1:0] BURST_INCR    = 2'b01;
  localparam logic [3:0] CACHE_DEFAULT = 4'b0011;
  localparam logic [2:0] PROT_DEFAULT  = 3'b000;
  localparam logic [1:0] RESP_OKAY     = 2'b00;

  localparam int unsigned PAGE_4K    = 4096;
  localparam int unsigned BEAT_BYTES = 8;

  // AWLEN for the next burst: the smallest of the burst cap, the beats left
  // and the beats up to the next 4 KB page. Caller guarantees remaining > 0.
  function automatic logic [7:0] calc_awlen(
    input logic [8:0]  page_word,
    input logic [28:0] remaining,
    input int unsigned max_burst
  );
    int unsigned beats;
    int unsigned to_page;
    to_page = (PAGE_4K / BEAT_BYTES) - 32'(page_word);
    beats   = 32'(remaining);
    if (beats > max_burst) beats = max_burst;
    if (beats > to_page) beats = to_page;
    return 8'(beats - 1);
  endfunction

endpackage

// File: rtl/aq_axi_sdma64_wr_master.sv
// AXI4 write master: streams a byte range from a FWFT FIFO as 64-bit INCR
// bursts, one burst outstanding at a time, never crossing a 4 KB page.
module aq_axi_sdma64_wr_master
  import aq_axi_sdma64_pkg::*;
#(
  parameter int unsigned MAX_BURST = 16
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic        WR_START,
  input  logic [31:0] WR_ADRS,
  input  logic [31:0] WR_COUNT,
  output logic        WR_READY,
  output logic        WR_INT,
  output logic        WR_ERR,
  input  logic [63:0] FIFO_DATA,
  input  logic        FIFO_EMPTY,
  output logic        FIFO_RDEN,
  output logic [31:0] M_AXI_AWADDR,
  output logic [7:0]  M_AXI_AWLEN,
  output logic [2:0]  M_AXI_AWSIZE,
  output logic [1:0]  M_AXI_AWBURST,
  output logic [3:0]  M_AXI_AWCACHE,
  output logic [2:0]  M_AXI_AWPROT,
  output logic        M_AXI_AWVALID,
  input  logic        M_AXI_AWREADY,
  output logic [63:0] M_AXI_WDATA,
  output logic [7:0]  M_AXI_WSTRB,
  output logic        M_AXI_WLAST,
  output logic        M_AXI_WVALID,
  input  logic        M_AXI_WREADY,
  input  logic [1:0]  M_AXI_BRESP,
  input  logic        M_AXI_BVALID,
  output logic        M_AXI_BREADY
);

  logic [1:0]  r_state;
  logic [31:0] r_addr;
  logic [28:0] r_remain;
  logic [7:0]  r_awlen;
  logic [7:0]  r_beat_cnt;
  logic        r_int;
  logic        r_err;

  logic        w_in_data;
  logic        w_wvalid;
  logic        w_wlast;
  logic        w_whandshake;
  logic [8:0]  w_burst;
  logic [31:0] w_next_addr;
  logic [28:0] w_next_remain;
  logic        w_unused;

  // Byte offsets below the 64-bit word are discarded on start.
  assign w_unused = ^{WR_ADRS[2:0], WR_COUNT[2:0]};

  assign w_in_data     = (r_state == S_DATA);
  assign w_wvalid      = w_in_data && !FIFO_EMPTY;
  assign w_wlast       = w_in_data && (r_beat_cnt == r_awlen);
  assign w_whandshake  = w_wvalid && M_AXI_WREADY;
  assign w_burst       = {1'b0, r_awlen} + 9'd1;
  assign w_next_addr   = r_addr + {20'd0, w_burst, 3'd0};
  assign w_next_remain = r_remain - {20'd0, w_burst};

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_remain   <= '0;
      r_awlen    <= '0;
      r_beat_cnt <= '0;
      r_int      <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_int <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (WR_START) begin
            r_err      <= 1'b0;
            r_addr     <= {WR_ADRS[31:3], 3'b000};
            r_remain   <= WR_COUNT[31:3];
            r_beat_cnt <= '0;
            // A sub-word count completes immediately without touching the bus.
            if (WR_COUNT[31:3] == '0) begin
              r_int <= 1'b1;
            end else begin
              r_awlen <= calc_awlen(WR_ADRS[11:3], WR_COUNT[31:3], MAX_BURST);
              r_state <= S_ADDR;
            end
          end
        end
        S_ADDR: begin
          if (M_AXI_AWREADY) r_state <= S_DATA;
        end
        S_DATA: begin
          if (w_whandshake) begin
            if (w_wlast) begin
              r_beat_cnt <= '0;
              r_state    <= S_RESP;
            end else begin
              r_beat_cnt <= r_beat_cnt + 8'd1;
            end
          end
        end
        S_RESP: begin
          if (M_AXI_BVALID) begin
            if (M_AXI_BRESP != RESP_OKAY) r_err <= 1'b1;
            r_addr   <= w_next_addr;
            r_remain <= w_next_remain;
            if (w_next_remain != '0) begin
              r_awlen <= calc_awlen(w_next_addr[11:3], w_next_remain, MAX_BURST);
              r_state <= S_ADDR;
            end else begin
              r_int   <= 1'b1;
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign WR_READY      = (r_state == S_IDLE);
  assign WR_INT        = r_int;
  assign WR_ERR        = r_err;
  assign FIFO_RDEN     = w_whandshake;

  assign M_AXI_AWADDR  = r_addr;
  assign M_AXI_AWLEN   = r_awlen;
  assign M_AXI_AWSIZE  = SIZE_64;
  assign M_AXI_AWBURST = BURST_INCR;
  assign M_AXI_AWCACHE = CACHE_DEFAULT;
  assign M_AXI_AWPROT  = PROT_DEFAULT;
  assign M_AXI_AWVALID = (r_state == S_ADDR);

  assign M_AXI_WDATA   = w_in_data ? FIFO_DATA : 64'd0;
  assign M_AXI_WSTRB   = 8'hFF;
  assign M_AXI_WLAST   = w_wlast;
  assign M_AXI_WVALID  = w_wvalid;

  assign M_AXI_BREADY  = (r_state == S_RESP);

endmodule
